// File: rtl/morse_pkg.sv
// Shared Morse types and timing constants for the
// transmit encoder and the ASCII lookup table.
package morse_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_SPACE,
    S_CHAR_GAP,
    S_WORD_GAP
  } state_t;

  localparam int DOT_U        = 1;
  localparam int DASH_U       = 3;
  localparam int SYM_GAP_U    = 1;
  localparam int CHAR_GAP_U   = 3;
  localparam int WORD_EXTRA_U = 4;
  localparam int MAX_LEN      = 5;

  typedef struct packed {
    logic       valid;
    logic       is_space;
    logic [2:0] len;
    logic [4:0] pat;
  } morse_ent_t;

  function automatic logic [2:0] sym_units(input logic dash);
    return dash ? 3'(DASH_U) : 3'(DOT_U);
  endfunction

endpackage

// File: rtl/morse_encoder_tx_if.sv
// Character valid/ready link into the Morse encoder.
interface morse_encoder_tx_if;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;

  modport master (
    output char_in,
    output char_valid,
    input  char_ready
  );

  modport slave (
    input  char_in,
    input  char_valid,
    output char_ready
  );
endinterface

// File: rtl/morse_lut.sv
// Combinational ASCII to Morse entry table; letters are
// case-folded, space is the word-gap code.
module morse_lut
  import morse_pkg::*;
(
  input  logic [7:0] ch,
  output morse_ent_t ent
);

  // b lists symbols left to right in its low n bits
  function automatic morse_ent_t sym(
    input logic [2:0] n,
    input logic [4:0] b
  );
    morse_ent_t e;
    e       = '0;
    e.valid = 1'b1;
    e.len   = n;
    for (int i = 0; i < MAX_LEN; i++)
      if (i < int'(n))
        e.pat[i] = b[n - 3'(i) - 3'd1];
    return e;
  endfunction

  logic [7:0] c;

  always_comb begin
    c = (ch >= 8'h61 && ch <= 8'h7a) ? ch - 8'h20 : ch;
    ent = '0;
    case (c)
      8'h20: begin
        ent.valid    = 1'b1;
        ent.is_space = 1'b1;
      end
      8'h41: ent = sym(3'd2, 5'b01);
      8'h42: ent = sym(3'd4, 5'b1000);
      8'h43: ent = sym(3'd4, 5'b1010);
      8'h44: ent = sym(3'd3, 5'b100);
      8'h45: ent = sym(3'd1, 5'b0);
      8'h46: ent = sym(3'd4, 5'b0010);
      8'h47: ent = sym(3'd3, 5'b110);
      8'h48: ent = sym(3'd4, 5'b0000);
      8'h49: ent = sym(3'd2, 5'b00);
      8'h4a: ent = sym(3'd4, 5'b0111);
      8'h4b: ent = sym(3'd3, 5'b101);
      8'h4c: ent = sym(3'd4, 5'b0100);
      8'h4d: ent = sym(3'd2, 5'b11);
      8'h4e: ent = sym(3'd2, 5'b10);
      8'h4f: ent = sym(3'd3, 5'b111);
      8'h50: ent = sym(3'd4, 5'b0110);
      8'h51: ent = sym(3'd4, 5'b1101);
      8'h52: ent = sym(3'd3, 5'b010);
      8'h53: ent = sym(3'd3, 5'b000);
      8'h54: ent = sym(3'd1, 5'b1);
      8'h55: ent = sym(3'd3, 5'b001);
      8'h56: ent = sym(3'd4, 5'b0001);
      8'h57: ent = sym(3'd3, 5'b011);
      8'h58: ent = sym(3'd4, 5'b1001);
      8'h59: ent = sym(3'd4, 5'b1011);
      8'h5a: ent = sym(3'd4, 5'b1100);
      8'h30: ent = sym(3'd5, 5'b11111);
      8'h31: ent = sym(3'd5, 5'b01111);
      8'h32: ent = sym(3'd5, 5'b00111);
      8'h33: ent = sym(3'd5, 5'b00011);
      8'h34: ent = sym(3'd5, 5'b00001);
      8'h35: ent = sym(3'd5, 5'b00000);
      8'h36: ent = sym(3'd5, 5'b10000);
      8'h37: ent = sym(3'd5, 5'b11000);
      8'h38: ent = sym(3'd5, 5'b11100);
      8'h39: ent = sym(3'd5, 5'b11110);
      default: ent = '0;
    endcase
  end

endmodule

// File: rtl/morse_encoder_tx.sv
// Morse keying transmitter: one ASCII character per
// handshake, timed in units of UNIT_CYCLES clocks.
module morse_encoder_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  morse_encoder_tx_if.slave link,
  output logic             key_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = $clog2(UNIT_CYCLES);
  localparam logic [CNT_W-1:0] U_LAST =
    CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] G_LAST =
    CNT_W'(UNIT_CYCLES - 2);

  state_t           state, state_n;
  logic [CNT_W-1:0] ucnt, ucnt_n;
  logic [2:0]       left, left_n;
  logic [2:0]       idx, idx_n;
  logic [2:0]       len, len_n;
  logic [4:0]       pat, pat_n;
  logic             done_n, err_n;
  logic             accept, tick, last, gap_last;
  morse_ent_t       ent;

  morse_lut u_lut (
    .ch  (link.char_in),
    .ent (ent)
  );

  assign link.char_ready = (state == S_IDLE);
  assign accept   = link.char_valid && link.char_ready;
  assign tick     = (ucnt == U_LAST);
  assign last     = tick && (left == 3'd1);
  // Gaps end a cycle early: the IDLE/done cycle is the final gap cycle
  assign gap_last = (ucnt == G_LAST) && (left == 3'd1);

  always_comb begin
    state_n = state;
    ucnt_n  = tick ? '0 : ucnt + 1'b1;
    left_n  = tick ? left - 3'd1 : left;
    idx_n   = idx;
    len_n   = len;
    pat_n   = pat;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      S_IDLE: begin
        ucnt_n = '0;
        left_n = '0;
        if (accept) begin
          if (!ent.valid) begin
            err_n = 1'b1;
          end else if (ent.is_space) begin
            state_n = S_WORD_GAP;
            left_n  = 3'(WORD_EXTRA_U);
          end else begin
            state_n = S_MARK;
            idx_n   = '0;
            len_n   = ent.len;
            pat_n   = ent.pat;
            left_n  = sym_units(ent.pat[0]);
          end
        end
      end
      S_MARK: begin
        if (last) begin
          if (idx + 3'd1 < len) begin
            state_n = S_SPACE;
            left_n  = 3'(SYM_GAP_U);
          end else begin
            state_n = S_CHAR_GAP;
            left_n  = 3'(CHAR_GAP_U);
          end
        end
      end
      S_SPACE: begin
        if (last) begin
          state_n = S_MARK;
          idx_n   = idx + 3'd1;
          left_n  = sym_units(pat[idx_n]);
        end
      end
      S_CHAR_GAP, S_WORD_GAP: begin
        if (gap_last) begin
          state_n = S_IDLE;
          ucnt_n  = '0;
          left_n  = '0;
          done_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ucnt    <= '0;
      left    <= '0;
      idx     <= '0;
      len     <= '0;
      pat     <= '0;
      key_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      ucnt    <= ucnt_n;
      left    <= left_n;
      idx     <= idx_n;
      len     <= len_n;
      pat     <= pat_n;
      key_out <= (state_n == S_MARK);
      busy    <= (state_n != S_IDLE);
      done    <= done_n;
      err     <= err_n;
    end
  end

endmodule

// File: tb/tb_morse_encoder_tx.sv
// Scoreboard bench for morse_encoder_tx against a
// dot/dash string reference model.
module tb_morse_encoder_tx;

  localparam int U = 4;

  typedef struct {
    int           n;
    logic [127:0] tr;
    bit           is_err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_out, busy, done, err;

  morse_encoder_tx_if link ();

  morse_encoder_tx #(.UNIT_CYCLES(U)) dut (
    .clk     (clk),
    .rst     (rst),
    .link    (link),
    .key_out (key_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  string alpha [26] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.",
    "....", "..", ".---", "-.-", ".-..", "--", "-.",
    "---", ".--.", "--.-", ".-.", "...", "-", "..-",
    "...-", ".--", "-..-", "-.--", "--.."};
  string digit [10] = '{
    "-----", ".----", "..---", "...--", "....-",
    ".....", "-....", "--...", "---..", "----."};

  exp_t exp_q [$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   cap = 0;
  int   cnt = 0;
  int   cyc = 0;
  int   fall_cyc = 0;
  int   last_gap = 0;
  int   pulses = 0;
  logic [127:0] tr;
  bit   busy_bad;
  logic prev_key = 1'b0;

  // key_out per cycle after accept, up to and including done
  function automatic exp_t model(input logic [7:0] c);
    exp_t  e;
    string s;
    int    ci, p, m;
    ci = int'(c);
    e.n = 0;
    e.tr = '0;
    e.is_err = 0;
    s = "";
    if (ci >= 97 && ci <= 122) s = alpha[ci - 97];
    else if (ci >= 65 && ci <= 90) s = alpha[ci - 65];
    else if (ci >= 48 && ci <= 57) s = digit[ci - 48];
    if (ci == 32) begin
      e.n = 7 * U - 3 * U;
      return e;
    end
    if (s.len() == 0) begin
      e.n = 1;
      e.is_err = 1;
      return e;
    end
    p = 0;
    for (int i = 0; i < s.len(); i++) begin
      m = (s[i] == "-") ? 3 * U : U;
      for (int k = 0; k < m; k++) begin
        e.tr[p[6:0]] = 1'b1;
        p++;
      end
      p += (i == s.len() - 1) ? 3 * U : U;
    end
    e.n = p;
    return e;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (key_out === 1'b1 && prev_key !== 1'b1)
        last_gap = cyc - fall_cyc;
      if (key_out !== 1'b1 && prev_key === 1'b1)
        fall_cyc = cyc;
      prev_key = key_out;
      if (rst) begin
        cap = 0;
      end else begin
        if (done || err) pulses++;
        if (cap) begin
          if (cnt < 128) tr[cnt] = key_out;
          cnt++;
          if (!done && !err && busy !== 1'b1)
            busy_bad = 1;
        end
        if (done || err) begin
          if (!cap || exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_pulse: done=%0b err=%0b",
                     done, err);
          end else begin
            e = exp_q.pop_front();
            chk("char_cycles", cnt, e.n);
            chk("err_flag", err, e.is_err);
            chk("done_flag", done, !e.is_err);
            chk("ready_at_end", link.char_ready, 1);
            chk("busy_profile", busy_bad | busy, 0);
            vectors++;
            if (tr !== e.tr) begin
              miscompares++;
              $display("FAIL key_trace: got %h expected %h",
                       tr, e.tr);
            end
          end
          cap = 0;
        end
        if (link.char_valid && link.char_ready) begin
          cap = 1;
          cnt = 0;
          tr = '0;
          busy_bad = 0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] c, input bit hold);
    int t;
    t = 0;
    link.char_in = c;
    link.char_valid = 1'b1;
    exp_q.push_back(model(c));
    do begin
      @(negedge clk);
      t++;
    end while (link.char_ready !== 1'b1 && t < 300);
    if (link.char_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: char %h not taken", c);
    end
    @(posedge clk);
    #1;
    if (!hold) link.char_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || cap) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0 || cap) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d outstanding",
               exp_q.size());
      exp_q.delete();
      cap = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] c;
    int r, p0;
    bit hold;
    link.char_in = 8'h00;
    link.char_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_key", key_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", link.char_ready, 1);
    @(posedge clk);
    #1;

    send("E", 0);
    drain();
    send("a", 0);
    drain();
    send("0", 1);
    send("5", 0);
    drain();
    send("?", 0);
    drain();
    send("T", 1);
    send(" ", 1);
    send("T", 0);
    drain();
    chk("word_gap_low", last_gap, 7 * U);

    link.char_in = "T";
    link.char_valid = 1'b1;
    r = 0;
    do begin
      @(negedge clk);
      r++;
    end while (link.char_ready !== 1'b1 && r < 300);
    @(posedge clk);
    #1 link.char_valid = 1'b0;
    repeat (6) @(posedge clk);
    chk("abort_pre_key", key_out, 1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    p0 = pulses;
    @(negedge clk);
    chk("abort_key", key_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", link.char_ready, 1);
    repeat (20) @(negedge clk);
    chk("abort_no_pulse", pulses - p0, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) c = 8'($urandom_range(65, 90));
      else if (r < 6) c = 8'($urandom_range(97, 122));
      else if (r < 8) c = 8'($urandom_range(48, 57));
      else if (r < 9) c = 8'h20;
      else c = 8'($urandom_range(0, 255));
      hold = (i != 29) && ($urandom_range(0, 1) == 1);
      send(c, hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/morse_encoder_tx.md
Name: morse_encoder_tx

Overview:
Transmit-side counterpart of the button-keyed Morse receive path. Accepts one ASCII character per valid/ready handshake and drives a single keying line (key_out) with standard Morse timing: dot 1 unit, dash 3 units, 1-unit intra-character gap, 3-unit inter-character gap, 7-unit word gap. key_out drives an LED/buzzer pin or loops back into the receiver for self-test.

Parameters:
UNIT_CYCLES, 1000, clock cycles per Morse time unit (≥2)
CNT_W, $clog2(UNIT_CYCLES), width of unit-cycle counter (derived, localparam)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
char_in  in  8  ASCII character to send
char_valid  in  1  char_in valid
char_ready  out  1  encoder can accept a character
key_out  out  1  keying output, 1 = tone/mark
busy  out  1  character in progress (not IDLE)
done  out  1  one-cycle pulse when a character (incl. space) completes
err  out  1  one-cycle pulse when an unsupported character is rejected

Behaviour:
- Reset: one clock, synchronous, active-high. State=IDLE, counters=0, key_out=0, busy=0, done=0, err=0. char_ready=1 once rst deasserts. rst asserted mid-character aborts immediately; key_out=0 the cycle after the rst edge; no done pulse.
- Interface: clock and reset are clk and rst; one clock domain; reset is synchronous and active-high.
- Handshake: char_ready = (state==IDLE), combinational from state. Accept on a rising edge with char_valid && char_ready. char_in is sampled only at accept; later changes are ignored.
- Lookup (combinational): A–Z and a–z (case-folded) plus 0–9 map to {len[2:0], pat[4:0]}. len is 1..5. pat is LSB-first, 1=dash, 0=dot. 0x20 (space) is the word-gap code. Every other byte is unsupported.
- States: IDLE, MARK, SPACE, CHAR_GAP, WORD_GAP.
- Unit timing: unit counter counts 0..UNIT_CYCLES-1 and resets on every state entry. A unit count tracks the remaining units in the current state.
- IDLE + accept of a supported letter or digit:
  - Next state is MARK. key_out=1 from the following cycle (1-cycle latency).
  - Symbol index 0. Duration is 1 unit for a dot, 3 units for a dash.
- MARK end:
  - If more symbols remain: go to SPACE (1 unit, key_out=0), then MARK for the next symbol.
  - After the last symbol: go to CHAR_GAP (3 units, key_out=0).
- IDLE + accept of space: go to WORD_GAP for 4 units, key_out=0. Combined with the preceding 3-unit CHAR_GAP this gives 7 units between words.
- CHAR_GAP or WORD_GAP end: return to IDLE and pulse done=1 in that same cycle. char_ready=1 in the same cycle, so back-to-back characters incur no extra idle cycles.
- IDLE + accept of an unsupported byte: err=1 the next cycle, state stays IDLE, key_out stays 0, no done. char_ready remains 1, so the byte is consumed.
- key_out, busy, done and err are all registered outputs.
- Simultaneous events: rst has priority over everything. char_valid outside IDLE has no effect.

Decomposition:
- morse_pkg holds:
  - state enum
  - unit constants DOT_U=1, DASH_U=3, SYM_GAP_U=1, CHAR_GAP_U=3, WORD_EXTRA_U=4
  - MAX_LEN=5
  - encoded-entry typedef {valid, is_space, len[2:0], pat[4:0]}
- Sub-module morse_lut: purely combinational ASCII → entry table, shared with the receive-side decoder tests.

Test Plan:
1. UNIT_CYCLES=4, send 'E' -> key_out=1 for exactly 4 cycles starting 1 cycle after accept, then 0 for 12 cycles. done pulses on cycle 16 after accept, with char_ready=1 that cycle.
2. Send 'a' -> same waveform as 'A': high 4, low 4, high 12, low 12. done after 32 cycles.
3. Send '0' then '5' back-to-back, char_valid held high -> 5 dashes (high 12 / low 4 between, 12 after last). '5' is accepted in the done cycle; its first mark starts the next cycle; 5 dots follow.
4. Send '?' (0x3F) -> err=1 one cycle after accept, key_out never rises, done=0, char_ready stays 1.
5. Send 'T', ' ', 'T' -> low interval between the two marks = 12 + 16 = 28 cycles (7 units). Two done pulses precede the second 'T'.
6. Assert rst for 1 cycle mid-dash of 'T' -> key_out=0, busy=0, char_ready=1 the cycle after the rst edge. No done or err pulses.
